popcount_seq: RTL and testbench

Sequential population-count engine. It accepts one WIDTH-bit word per transaction and walks it CHUNK bits per cycle through a single shared combinational chunk counter. It accumulates the result and returns the total ones-count over a valid/ready output. This lets wide words be counted with one small popcount datapath instead of a full-width adder tree.

---
 rtl/popcount_pkg.sv | 20 ++
 rtl/pop_count_chunk.sv | 17 +
 rtl/popcount_seq.sv | 92 +++++++++
 tb/tb_popcount_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/popcount_pkg.sv
// Shared types and helpers for the sequential popcount engine.
// Configuration legality is evaluated at elaboration time by the top.
package popcount_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width needed to hold a ones-count in the range 0..width.
  function automatic int cw_of(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic bit width_ok(input int width, input int chunk);
    return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/pop_count_chunk.sv
// Generic combinational ones-counter for a CHUNK-bit slice.
module pop_count_chunk #(
  parameter int CHUNK = 3,
  localparam int PW = $clog2(CHUNK + 1)
) (
  input  logic [CHUNK-1:0] bits_i,
  output logic [PW-1:0]    count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < CHUNK; i++) begin
      count_o = count_o + PW'(bits_i[i]);
    end
  end

endmodule

// File: rtl/popcount_seq.sv
// Sequential popcount: walks a captured word CHUNK bits per cycle through
// one shared chunk counter and returns the total over a valid/ready port.
module popcount_seq
  import popcount_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int CHUNK = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [cw_of(WIDTH)-1:0]    out_count,
  output logic                       busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = cw_of(WIDTH);
  localparam int PW     = $clog2(CHUNK + 1);
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (!width_ok(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("popcount_seq: WIDTH must be a positive multiple of CHUNK");
  end

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  sh_q, sh_d;
  logic [CW-1:0]     acc_q, acc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [PW-1:0]     chunk_cnt;

  pop_count_chunk #(.CHUNK(CHUNK)) u_chunk (
    .bits_i  (sh_q[CHUNK-1:0]),
    .count_o (chunk_cnt)
  );

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sh_d    = in_data;
          acc_d   = '0;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Lowest chunk is consumed each cycle; the last add lands as we enter DONE.
        acc_d = acc_q + CW'(chunk_cnt);
        sh_d  = sh_q >> CHUNK;
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(NCHUNK - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
    end
  end

  // Outputs decode registered state only, so no input reaches an output.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_count = acc_q;

endmodule

// File: tb/tb_popcount_seq.sv
// Bench for popcount_seq: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level reference model.
module tb_popcount_seq;

  localparam int WIDTH  = 24;
  localparam int CHUNK  = 3;
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = $clog2(WIDTH + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [CW-1:0]     out_count;
  logic              busy;

  int total = 0;
  int bad   = 0;

  popcount_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a word is owned for NCHUNK edges, then its ones-count
  // is offered until the consumer takes it.
  bit m_idle = 1'b1;
  int m_left = 0;
  int m_res  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idle <= 1'b1;
      m_left <= 0;
      m_res  <= 0;
    end else if (m_idle) begin
      if (in_valid) begin
        m_idle <= 1'b0;
        m_left <= NCHUNK;
        m_res  <= $countones(in_data);
      end
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
    end else if (out_ready) begin
      m_idle <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_count", out_count, 0);
      check("rst_busy", busy, 0);
    end else begin
      check("cmp_in_ready", in_ready, m_idle);
      check("cmp_busy", busy, !m_idle);
      check("cmp_out_valid", out_valid, (!m_idle && m_left == 0));
      if (!m_idle && m_left == 0) check("cmp_out_count", out_count, m_res);
    end
  end

  int cyc = 0;
  int acc_edges[$];
  int res_q[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid && in_ready) acc_edges.push_back(cyc);
    if (out_valid && out_ready) res_q.push_back(int'(out_count));
  end

  // Leaves the bench in the first cycle where out_valid is high.
  task automatic run_word(input logic [WIDTH-1:0] w, input int exp, input string nm,
                          input bit scramble);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check({nm, "_ready_wait"}, in_ready, 1);
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      check({nm, "_busy"}, busy, 1);
      if (scramble) in_data = WIDTH'($urandom());
      tick();
      n++;
    end
    check({nm, "_latency"}, n, NCHUNK);
    check({nm, "_count"}, out_count, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    run_word(24'h000000, 0, "zeros", 1'b0);
    tick();
    run_word(24'hFFFFFF, 24, "ones", 1'b0);
    tick();
    run_word(24'hA5A5A5, 12, "a5", 1'b0);
    tick();

    // Output backpressure
    out_ready = 1'b0;
    run_word(24'hA5A5A5, 12, "bp", 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_count", out_count, 12);
      check("bp_hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_ready", in_ready, 1);
    check("bp_release_valid", out_valid, 0);

    // Reset mid-operation
    in_valid = 1'b1;
    in_data  = 24'hFFFFFF;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("rstmid_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_in_ready", in_ready, 1);
    check("rstmid_out_valid", out_valid, 0);
    check("rstmid_out_count", out_count, 0);
    check("rstmid_busy", busy, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    run_word(24'h000001, 1, "after_rst", 1'b0);
    tick();

    // Back-to-back words with in_valid held high
    acc_edges.delete();
    res_q.delete();
    in_valid = 1'b1;
    in_data  = 24'h00000F;
    n = 0;
    while (acc_edges.size() < 1 && n < 20) begin
      tick();
      n++;
    end
    in_data = 24'h800000;
    while (acc_edges.size() < 2 && n < 60) begin
      tick();
      n++;
    end
    in_valid = 1'b0;
    while (res_q.size() < 2 && n < 100) begin
      tick();
      n++;
    end
    check("b2b_accepts", acc_edges.size(), 2);
    check("b2b_results", res_q.size(), 2);
    if (acc_edges.size() >= 2) check("b2b_gap", acc_edges[1] - acc_edges[0], NCHUNK + 2);
    if (res_q.size() >= 2) begin
      check("b2b_res0", res_q[0], 4);
      check("b2b_res1", res_q[1], 1);
    end
    tick();

    // Input changes after accept
    run_word(24'h000007, 3, "chg", 1'b1);
    in_data = '0;
    tick();

    // Randomized traffic, occasional asynchronous reset
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = WIDTH'($urandom());
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (NCHUNK + 4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
